pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
//
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32I pipeline.
//  - Merges the ID-stage load-use stall, the EX branch redirect, the multi-cycle mul/div
//    wait, the data-memory wait and the halt request.
//  - Drives one enable and one flush per pipeline register, plus the PC enable.
//  - Sits beside the data hazard controller. Consumes its stall output as load_use_stall.
//
// PARAMETERS
//  CNT_W       32  width of stall_cycles performance counter (saturating)
//  MD_MAX_CYC  64  max MD_WAIT cycles before md_timeout; range 2..2^16-1
//
// PORTS
//  clk             in   1      clock, all state on posedge
//  rst             in   1      synchronous reset, active-high
//  halt_req        in   1      ecall/ebreak retiring in WB (level)
//  dmem_req        in   1      MEM stage holds a load/store this cycle
//  dmem_ready      in   1      data memory completes MEM access this cycle
//  md_req          in   1      unresolved mul/div in EX (level until md_done)
//  md_done         in   1      mul/div result valid this cycle (pulse)
//  branch_taken    in   1      EX resolved taken branch/jump; PC redirected
//  load_use_stall  in   1      load-use hazard between ID and IF
//  pc_en           out  1      PC register update enable
//  if_id_en        out  1      IF/ID register enable
//  id_ex_en        out  1      ID/EX register enable
//  ex_mem_en       out  1      EX/MEM register enable
//  mem_wb_en       out  1      MEM/WB register enable
//  if_id_flush     out  1      load bubble (NOP) into IF/ID; overrides its enable
//  id_ex_flush     out  1      load bubble into ID/EX; overrides its enable
//  ex_mem_flush    out  1      load bubble into EX/MEM; overrides its enable
//  halted          out  1      core halted (state HALTED)
//  md_timeout      out  1      sticky: mul/div exceeded MD_MAX_CYC
//  stall_cycles    out  CNT_W  cycles with pc_en=0 while not HALTED
//  seq_state       out  2      RUN=0, MEM_WAIT=1, MD_WAIT=2, HALTED=3
//
// BEHAVIOUR
//  Reset
//   - rst=1: next state RUN; md_cnt, stall_cycles and md_timeout cleared.
//   - While rst=1: all *_en=0, all *_flush=1, halted=0.
//  Outputs
//   - Combinational from state and inputs; zero-cycle latency.
//   - Default for every cycle: all en=1, all flush=0.
//  RUN: first matching rule wins.
//   1. halt_req: all en=0 -> HALTED.
//   2. dmem_req & !dmem_ready: all en=0 -> MEM_WAIT.
//   3. md_req & !md_done: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1; md_cnt<=1 -> MD_WAIT.
//   4. branch_taken: if_id_flush=id_ex_flush=1; load_use_stall is ignored.
//   5. load_use_stall: pc_en=0, if_id_flush=1 (IF instruction refetched next cycle).
//   6. Otherwise: free run.
//  MEM_WAIT
//   - dmem_ready=0: all en=0; state held.
//   - dmem_ready=1: evaluate rules 3..6 as in RUN -> RUN, or MD_WAIT if rule 3 fires.
//   - halt_req is not sampled in MEM_WAIT.
//  MD_WAIT
//   - Normal cycle: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1, mem_wb_en=1; md_cnt++.
//   - md_done=1: all en=1, no flush -> RUN. The result is captured into EX/MEM.
//   - md_done=0 and md_cnt==MD_MAX_CYC: set md_timeout, all en=0 -> HALTED.
//   - md_done and timeout in the same cycle: md_done wins.
//   - MEM holds only bubbles here, so dmem_req is ignored.
//  HALTED
//   - All en=0, flush=0, halted=1.
//   - Terminal state; left only by rst.
//  stall_cycles
//   - +1 on every cycle with rst=0, state!=HALTED and pc_en=0.
//   - Saturates at 2^CNT_W-1; never wraps.
//  Reset mid-operation
//   - rst overrides all states and inputs in the same cycle.
//   - An outstanding mem or mul/div transaction is abandoned.
//
// TESTING
//  T1 load-use:
//   - load_use_stall=1 for 1 cycle in RUN -> pc_en=0, if_id_flush=1 that cycle.
//   - stall_cycles 0->1; state stays RUN.
//  T2 branch beats load-use:
//   - branch_taken=1 with load_use_stall=1 -> pc_en=1, if_id_flush=id_ex_flush=1.
//   - stall_cycles unchanged.
//  T3 memory wait:
//   - dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all en=0 for 3 cycles.
//   - seq_state=1 on those cycles, back to 0; stall_cycles +3.
//  T4 mul/div:
//   - md_req=1, md_done on the 5th cycle.
//   - 4 cycles of ex_mem_flush=1, mem_wb_en=1, pc_en=0.
//   - md_done cycle all en=1 -> RUN.
//  T5 timeout:
//   - MD_MAX_CYC=4, md_req held with no md_done.
//   - md_timeout=1 and seq_state=3 after 4 MD_WAIT cycles; en=0 thereafter.
//   - rst clears everything.
//  T6 halt and reset:
//   - halt_req in RUN -> HALTED, halted=1 held for 10 cycles despite inputs.
//   - rst=1 for 1 cycle -> RUN, stall_cycles=0.
//   - Also pulse rst in MEM_WAIT -> RUN on the next cycle.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: merges hazard, branch, mul/div,
// data-memory and halt conditions into per-register enables and flushes.
module pipeline_sequencer #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MD_MAX_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             md_req,
  input  logic             md_done,
  input  logic             branch_taken,
  input  logic             load_use_stall,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       seq_state
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StMdWait  = 2'd2,
    StHalted  = 2'd3
  } state_e;

  localparam logic [15:0] MdMax = 16'(MD_MAX_CYC);

  state_e           state_q, state_d;
  logic [15:0]      md_cnt_q, md_cnt_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q;

  logic md_start;
  logic md_expired;

  assign md_start   = md_req & ~md_done;
  assign md_expired = ~md_done & (md_cnt_q == MdMax);

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    md_cnt_q     <= md_cnt_d;
    md_timeout_q <= md_timeout_d;
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;
    if (rst) begin
      state_d      = StRun;
      md_cnt_d     = '0;
      md_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (halt_req) begin
            state_d = StHalted;
          end else if (dmem_req && !dmem_ready) begin
            state_d = StMemWait;
          end else if (md_start) begin
            state_d  = StMdWait;
            md_cnt_d = 16'd1;
          end
        end
        StMemWait: begin
          if (dmem_ready) begin
            if (md_start) begin
              state_d  = StMdWait;
              md_cnt_d = 16'd1;
            end else begin
              state_d = StRun;
            end
          end
        end
        StMdWait: begin
          if (md_done) begin
            state_d = StRun;
          end else if (md_expired) begin
            state_d      = StHalted;
            md_timeout_d = 1'b1;
          end else begin
            md_cnt_d = md_cnt_q + 16'd1;
          end
        end
        StHalted: begin
          state_d = StHalted;
        end
      endcase
    end
  end

  always_comb begin
    logic all_off;
    logic eval_tail;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    all_off      = 1'b0;
    eval_tail    = 1'b0;
    if (rst) begin
      all_off      = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (halt_req || (dmem_req && !dmem_ready)) all_off = 1'b1;
          else                                       eval_tail = 1'b1;
        end
        StMemWait: begin
          if (!dmem_ready) all_off = 1'b1;
          else             eval_tail = 1'b1;
        end
        StMdWait: begin
          if (md_expired) begin
            all_off = 1'b1;
          end else if (!md_done) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
          end
        end
        StHalted: begin
          all_off = 1'b1;
          halted  = 1'b1;
        end
      endcase
    end
    // Rules shared by RUN and the completing MEM_WAIT cycle; branch beats load-use.
    if (eval_tail) begin
      if (md_start) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_stall) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
    if (all_off) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (state_q != StHalted && !pc_en && stall_cycles_q != {CNT_W{1'b1}}) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign md_timeout   = md_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized scoreboard bench for pipeline_sequencer; expectations come from a rule-level
// reference model, compared by a monitor on the falling edge.
module tb_pipeline_sequencer;

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned MD_MAX = 4;
  localparam int          VW     = 5 + 3 + 1 + 1 + CNT_W + 2;
  localparam int          SC_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, halt_req, dmem_req, dmem_ready, md_req, md_done, branch_taken, load_use_stall;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, halted, md_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0] seq_state;

  pipeline_sequencer #(.CNT_W(CNT_W), .MD_MAX_CYC(MD_MAX)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .md_req(md_req), .md_done(md_done), .branch_taken(branch_taken),
    .load_use_stall(load_use_stall), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] val;
    logic          full;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: mode 0=RUN 1=MEM_WAIT 2=MD_WAIT 3=HALTED.
  int mode = 0;
  int md_cycles = 0;
  bit to_flag = 0;
  int stalls = 0;
  bit known = 0;

  task automatic step(input logic [7:0] v);
    logic [4:0] en;
    logic [2:0] fl;
    logic       hl;
    bit         tail;
    int         nmode;
    exp_t       e;
    {rst, halt_req, dmem_req, dmem_ready, md_req, md_done, branch_taken, load_use_stall} = v;
    en = 5'b11111; fl = 3'b000; hl = 1'b0; tail = 0; nmode = mode;
    if (rst) begin
      en = 5'b00000; fl = 3'b111;
    end else begin
      if (mode == 0) begin
        if (halt_req)                     begin en = 0; nmode = 3; end
        else if (dmem_req && !dmem_ready) begin en = 0; nmode = 1; end
        else tail = 1;
      end else if (mode == 1) begin
        if (!dmem_ready) en = 0;
        else begin tail = 1; nmode = 0; end
      end else if (mode == 2) begin
        if (md_done) nmode = 0;
        else if (md_cycles == MD_MAX) begin en = 0; nmode = 3; end
        else begin en = 5'b00011; fl = 3'b001; end
      end else begin
        en = 0; hl = 1'b1;
      end
      if (tail) begin
        if (md_req && !md_done) begin en = 5'b00011; fl = 3'b001; nmode = 2; end
        else if (branch_taken) fl = 3'b110;
        else if (load_use_stall) begin en[4] = 1'b0; fl = 3'b100; end
      end
    end
    e.val  = {en, fl, hl, to_flag, CNT_W'(stalls), 2'(mode)};
    e.full = known;
    q.push_back(e);
    if (rst) begin
      mode = 0; md_cycles = 0; to_flag = 0; stalls = 0; known = 1;
    end else begin
      if (mode != 3 && !en[4] && stalls < SC_MAX) stalls++;
      if (mode == 2 && nmode == 3) to_flag = 1;
      if (nmode == 2) md_cycles = (mode == 2) ? md_cycles + 1 : 1;
      mode = nmode;
    end
  endtask

  task automatic cyc(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      step(v);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t          e;
      logic [VW-1:0] act;
      logic [VW-1:0] mask;
      e    = q.pop_front();
      act  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
              ex_mem_flush, halted, md_timeout, stall_cycles, seq_state};
      mask = e.full ? {VW{1'b1}} : {{9{1'b1}}, {(VW-9){1'b0}}};
      checks++;
      if (((act ^ e.val) & mask) != '0) begin
        errors++;
        $display("FAIL outputs t=%0t got en=%b fl=%b h=%b to=%b sc=%0d st=%0d want en=%b fl=%b h=%b to=%b sc=%0d st=%0d",
                 $time, act[VW-1-:5], act[VW-6-:3], act[VW-9], act[VW-10], act[CNT_W+1:2],
                 act[1:0], e.val[VW-1-:5], e.val[VW-6-:3], e.val[VW-9], e.val[VW-10],
                 e.val[CNT_W+1:2], e.val[1:0]);
      end
    end
  end

  // Stimulus bits: {rst, halt, dreq, drdy, mdreq, mddone, branch, load_use}
  initial begin
    logic [7:0] v;
    cyc(8'h80, 2);
    cyc(8'h01, 1); cyc(8'h00, 1);                  // load-use
    cyc(8'h03, 1); cyc(8'h00, 1);                  // branch beats load-use
    cyc(8'h20, 3); cyc(8'h30, 1); cyc(8'h00, 1);   // memory wait
    cyc(8'h08, 4); cyc(8'h0C, 1); cyc(8'h00, 1);   // mul/div done on 5th cycle
    cyc(8'h08, 7); cyc(8'h7F, 3); cyc(8'h80, 1);   // timeout then reset
    cyc(8'h40, 1);                                 // halt
    for (int i = 0; i < 10; i++) cyc(8'($urandom) & 8'h7F, 1);
    cyc(8'h80, 1); cyc(8'h00, 1);
    cyc(8'h20, 2); cyc(8'h80, 1); cyc(8'h00, 2);   // reset during MEM_WAIT
    cyc(8'h01, 70); cyc(8'h00, 1);                 // stall counter saturation
    cyc(8'h20, 1); cyc(8'h38, 1); cyc(8'h0C, 1);   // MEM_WAIT exit straight into MD_WAIT
    for (int i = 0; i < 3000; i++) begin
      v[7] = ($urandom_range(0, 59) == 0);
      v[6] = ($urandom_range(0, 39) == 0);
      v[5] = ($urandom_range(0, 2) == 0);
      v[4] = ($urandom_range(0, 1) == 0);
      v[3] = ($urandom_range(0, 3) == 0);
      v[2] = ($urandom_range(0, 2) == 0);
      v[1] = ($urandom_range(0, 3) == 0);
      v[0] = ($urandom_range(0, 2) == 0);
      cyc(v, 1);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
